// File: rtl/fc_stream_engine.sv
// rtl/fc_stream_engine.sv - streaming fully-connected layer engine with bus master ports
// Computes y[j] = sat(relu?((b[j] << FRAC_BITS + sum_i x[i]*W[j][i]) >>> FRAC_BITS)).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, cfg_*                  launch and layer configuration (captured on accepted start)
//   busy, done, err               status; err is meaningful alongside done
//   araddr/arlen/arvalid/arready  read address channel (word addresses)
//   rdata/rvalid/rlast/rready     read data channel
//   awaddr/awlen/awvalid/awready  write address channel (single-beat writes)
//   wdata/wvalid/wlast/wready     write data channel
//   bvalid/bready                 write response channel
module fc_stream_engine #(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 16,
  parameter int ACC_W     = 64,
  parameter int FEAT_MAX  = 1024,
  parameter int BURST_MAX = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [27:0]                      cfg_x_addr,
  input  logic [27:0]                      cfg_w_addr,
  input  logic [27:0]                      cfg_b_addr,
  input  logic [27:0]                      cfg_y_addr,
  input  logic [$clog2(FEAT_MAX+1)-1:0]    cfg_feat_len,
  input  logic [15:0]                      cfg_out_len,
  input  logic                             cfg_relu,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic [27:0]                      araddr,
  output logic [3:0]                       arlen,
  output logic                             arvalid,
  input  logic                             arready,
  input  logic [DATA_W-1:0]                rdata,
  input  logic                             rvalid,
  input  logic                             rlast,
  output logic                             rready,
  output logic [27:0]                      awaddr,
  output logic [3:0]                       awlen,
  output logic                             awvalid,
  input  logic                             awready,
  output logic [DATA_W-1:0]                wdata,
  output logic                             wvalid,
  output logic                             wlast,
  input  logic                             wready,
  input  logic                             bvalid,
  output logic                             bready
);

  localparam int LEN_W = $clog2(FEAT_MAX + 1);
  localparam int IDX_W = $clog2(FEAT_MAX);

  typedef enum logic [3:0] {
    S_IDLE, S_XAR, S_XR, S_BAR, S_BR, S_WAR, S_WR,
    S_RES, S_AW, S_WD, S_WRESP, S_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_next;

  logic [LEN_W-1:0]          r_feat_len;
  logic [15:0]               r_out_len;
  logic                      r_relu;
  logic [27:0]               r_seg_addr;   // address of the next beat in the current segment
  logic [LEN_W-1:0]          r_seg_rem;    // words still to read in the current segment
  logic [27:0]               r_w_ptr;      // start of the next W row
  logic [27:0]               r_b_ptr;      // next bias word
  logic [27:0]               r_y_ptr;      // next output word
  logic [3:0]                r_beat;
  logic [IDX_W-1:0]          r_idx;
  logic [15:0]               r_j;
  logic signed [ACC_W-1:0]   r_acc;
  logic [DATA_W-1:0]         r_wdata;
  logic [27:0]               r_araddr;
  logic [3:0]                r_arlen;
  logic [27:0]               r_awaddr;
  logic                      r_err;
  logic [DATA_W-1:0]         r_xbuf [FEAT_MAX];

  logic                      w_cfg_bad;
  logic                      w_r_fire;
  logic                      w_last_beat;
  logic                      w_seg_done;
  logic                      w_row_last;
  logic [LEN_W-1:0]          w_rem_dec;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_bias;
  logic signed [ACC_W-1:0]   w_shift;
  logic [ACC_W-DATA_W:0]     w_hi;
  logic                      w_fits;
  logic [DATA_W-1:0]         w_sat;
  logic [DATA_W-1:0]         w_result;

  // Beats in the next burst, minus one: never more than BURST_MAX nor past the segment end.
  function automatic logic [3:0] f_arlen(input logic [LEN_W-1:0] rem);
    logic [LEN_W-1:0] beats;
    beats = (rem > LEN_W'(BURST_MAX)) ? LEN_W'(BURST_MAX) : rem;
    return 4'(beats - LEN_W'(1));
  endfunction

  assign w_cfg_bad   = (cfg_feat_len == '0) || (cfg_feat_len > LEN_W'(FEAT_MAX)) ||
                       (cfg_out_len == 16'd0);
  assign w_r_fire    = rvalid && rready;
  assign w_last_beat = (r_beat == r_arlen);
  assign w_seg_done  = (r_seg_rem == LEN_W'(1));
  assign w_rem_dec   = r_seg_rem - LEN_W'(1);
  assign w_row_last  = (r_j == r_out_len - 16'd1);

  assign w_prod  = $signed(r_xbuf[r_idx]) * $signed(rdata);
  assign w_bias  = {{(ACC_W-DATA_W){rdata[DATA_W-1]}}, rdata} << FRAC_BITS;

  // Result fits in DATA_W when every bit above the target sign bit equals it.
  assign w_shift  = r_acc >>> FRAC_BITS;
  assign w_hi     = w_shift[ACC_W-1:DATA_W-1];
  assign w_fits   = (&w_hi) | ~(|w_hi);
  assign w_sat    = w_fits ? w_shift[DATA_W-1:0] :
                    (w_shift[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}});
  assign w_result = (r_relu && w_sat[DATA_W-1]) ? '0 : w_sat;

  assign araddr = r_araddr;
  assign arlen  = r_arlen;
  assign awaddr = r_awaddr;
  assign awlen  = 4'd0;
  assign wdata  = r_wdata;
  assign err    = r_err;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; the beat counter, not rlast, closes each burst.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_cfg_bad ? S_DONE : S_XAR;
      S_XAR:   if (arready) w_next = S_XR;
      S_XR:    if (w_r_fire && w_last_beat) w_next = w_seg_done ? S_BAR : S_XAR;
      S_BAR:   if (arready) w_next = S_BR;
      S_BR:    if (w_r_fire) w_next = S_WAR;
      S_WAR:   if (arready) w_next = S_WR;
      S_WR:    if (w_r_fire && w_last_beat) w_next = w_seg_done ? S_RES : S_WAR;
      S_RES:   w_next = S_AW;
      S_AW:    if (awready) w_next = S_WD;
      S_WD:    if (wready) w_next = S_WRESP;
      S_WRESP: if (bvalid) w_next = w_row_last ? S_DONE : S_BAR;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy    = (r_state != S_IDLE) && (r_state != S_DONE);
    done    = (r_state == S_DONE);
    arvalid = (r_state == S_XAR) || (r_state == S_BAR) || (r_state == S_WAR);
    rready  = (r_state == S_XR) || (r_state == S_BR) || (r_state == S_WR);
    awvalid = (r_state == S_AW);
    wvalid  = (r_state == S_WD);
    wlast   = (r_state == S_WD);
    bready  = (r_state == S_WRESP);
  end

  // x buffer fill; left unreset since it is always refilled before use.
  always_ff @(posedge clk) begin
    if (r_state == S_XR && w_r_fire) r_xbuf[r_idx] <= rdata;
  end

  // Datapath, pointers and the next read burst descriptor
  always_ff @(posedge clk) begin
    if (rst) begin
      r_feat_len <= '0;
      r_out_len  <= '0;
      r_relu     <= 1'b0;
      r_seg_addr <= '0;
      r_seg_rem  <= '0;
      r_w_ptr    <= '0;
      r_b_ptr    <= '0;
      r_y_ptr    <= '0;
      r_beat     <= '0;
      r_idx      <= '0;
      r_j        <= '0;
      r_acc      <= '0;
      r_wdata    <= '0;
      r_araddr   <= '0;
      r_arlen    <= '0;
      r_awaddr   <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_err      <= w_cfg_bad;
            r_feat_len <= cfg_feat_len;
            r_out_len  <= cfg_out_len;
            r_relu     <= cfg_relu;
            r_seg_addr <= cfg_x_addr;
            r_seg_rem  <= cfg_feat_len;
            r_w_ptr    <= cfg_w_addr;
            r_b_ptr    <= cfg_b_addr;
            r_y_ptr    <= cfg_y_addr;
            r_j        <= '0;
            r_idx      <= '0;
            r_araddr   <= cfg_x_addr;
            r_arlen    <= f_arlen(cfg_feat_len);
          end
        end
        S_XAR, S_BAR, S_WAR: begin
          if (arready) r_beat <= '0;
        end
        S_XR, S_WR: begin
          if (w_r_fire) begin
            if (rlast != w_last_beat) r_err <= 1'b1;
            r_beat     <= r_beat + 4'd1;
            r_idx      <= r_idx + IDX_W'(1);
            r_seg_addr <= r_seg_addr + 28'd1;
            r_seg_rem  <= w_rem_dec;
            if (r_state == S_WR) r_acc <= r_acc + ACC_W'(w_prod);
            if (w_last_beat) begin
              if (!w_seg_done) begin
                r_araddr <= r_seg_addr + 28'd1;
                r_arlen  <= f_arlen(w_rem_dec);
              end else if (r_state == S_XR) begin
                r_araddr <= r_b_ptr;
                r_arlen  <= 4'd0;
              end else begin
                // W rows are contiguous, so the next row starts right after this one.
                r_w_ptr  <= r_seg_addr + 28'd1;
              end
            end
          end
        end
        S_BR: begin
          if (w_r_fire) begin
            if (!rlast) r_err <= 1'b1;
            r_acc      <= w_bias;
            r_b_ptr    <= r_b_ptr + 28'd1;
            r_seg_addr <= r_w_ptr;
            r_seg_rem  <= r_feat_len;
            r_idx      <= '0;
            r_araddr   <= r_w_ptr;
            r_arlen    <= f_arlen(r_feat_len);
          end
        end
        S_RES: begin
          r_wdata  <= w_result;
          r_awaddr <= r_y_ptr;
        end
        S_WRESP: begin
          if (bvalid) begin
            r_y_ptr <= r_y_ptr + 28'd1;
            r_j     <= r_j + 16'd1;
            if (!w_row_last) begin
              r_araddr <= r_b_ptr;
              r_arlen  <= 4'd0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
